// File: rtl/dct_stage2_seq.sv
// dct_stage2_seq
// Runs the column pass of an 8x8 DCT through one shared column unit. A block
// is accepted whole, its eight columns are presented to the external column
// unit one per cycle, the results are gathered into an output buffer, and the
// finished block is offered downstream with a valid/ready handshake.
//
// Optional feature macro: DCT_SEQ_COL_REG_EN
//   When defined, the column-unit result is registered for one cycle before
//   it is written to the output buffer. The write index lags the drive index
//   by one, and RUN gains one drain cycle (11 cycles per block instead of 10).
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  input block handshake
//   in_data         input block, in_data[c] is column c, in_data[c][r] row r
//   approx_req      approximate-mode request, sampled with the block
//   col_data_out    column driven to the shared column unit (zero outside RUN)
//   col_approx_en   approx enable for the column unit (latched bit, RUN only)
//   col_data_in     column-unit result for col_data_out
//   out_valid/ready output block handshake
//   out_data        result block, out_data[c] is column c result
//   busy            high while a block is in flight (RUN or DONE)
module dct_stage2_seq #(
  parameter int SIZE     = 10,
  parameter int SIZE_OUT = SIZE + 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [7:0][7:0][SIZE-1:0]          in_data,
  input  logic                               approx_req,
  output logic [7:0][SIZE-1:0]               col_data_out,
  output logic                               col_approx_en,
  input  logic [7:0][SIZE_OUT-1:0]           col_data_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [7:0][7:0][SIZE_OUT-1:0]      out_data,
  output logic                               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_reg;
  logic [2:0]                col_reg;
  logic                      approx_reg;
  logic [7:0][SIZE-1:0]      ibuf_reg [8];
  logic [7:0][SIZE_OUT-1:0]  obuf_reg [8];

  // Output-buffer write port and "driving a column this cycle" qualifier.
  logic                      wr_en;
  logic [2:0]                wr_col;
  logic [7:0][SIZE_OUT-1:0]  wr_data;
  logic                      drive;

`ifdef DCT_SEQ_COL_REG_EN
  logic [7:0][SIZE_OUT-1:0]  col_in_reg;
  logic [2:0]                wr_col_reg;
  logic                      wr_en_reg;
  logic                      drain_reg;   // final RUN cycle: nothing driven, last write lands

  assign wr_en   = wr_en_reg;
  assign wr_col  = wr_col_reg;
  assign wr_data = col_in_reg;
  assign drive   = (state_reg == RUN) && !drain_reg;
`else
  assign wr_en   = (state_reg == RUN);
  assign wr_col  = col_reg;
  assign wr_data = col_data_in;
  assign drive   = (state_reg == RUN);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      col_reg    <= 3'd0;
      approx_reg <= 1'b0;
      for (int c = 0; c < 8; c++) begin
        ibuf_reg[c] <= '0;
        obuf_reg[c] <= '0;
      end
`ifdef DCT_SEQ_COL_REG_EN
      col_in_reg <= '0;
      wr_col_reg <= 3'd0;
      wr_en_reg  <= 1'b0;
      drain_reg  <= 1'b0;
`endif
    end else begin
      if (wr_en) begin
        obuf_reg[wr_col] <= wr_data;
      end

      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            for (int c = 0; c < 8; c++) begin
              ibuf_reg[c] <= in_data[c];
            end
            approx_reg <= approx_req;
            col_reg    <= 3'd0;
            state_reg  <= RUN;
          end
        end

        RUN: begin
`ifdef DCT_SEQ_COL_REG_EN
          if (!drain_reg) begin
            col_in_reg <= col_data_in;
            wr_col_reg <= col_reg;
            wr_en_reg  <= 1'b1;
            col_reg    <= col_reg + 3'd1;
            if (col_reg == 3'd7) begin
              drain_reg <= 1'b1;
            end
          end else begin
            // Column 7 is written by the obuf port on this edge.
            wr_en_reg <= 1'b0;
            drain_reg <= 1'b0;
            state_reg <= DONE;
          end
`else
          col_reg <= col_reg + 3'd1;
          if (col_reg == 3'd7) begin
            state_reg <= DONE;
          end
`endif
        end

        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode only the state register and stored data, so there is no
  // combinational path from in_valid or out_ready.
  assign in_ready      = (state_reg == IDLE);
  assign out_valid     = (state_reg == DONE);
  assign busy          = (state_reg != IDLE);
  assign col_approx_en = (state_reg == RUN) && approx_reg;
  assign col_data_out  = drive ? ibuf_reg[col_reg] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_out
      assign out_data[gi] = obuf_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_dct_stage2_seq.sv
module tb_dct_stage2_seq;

  localparam int SIZE     = 10;
  localparam int SIZE_OUT = SIZE + 2;

`ifdef DCT_SEQ_COL_REG_EN
  localparam int LAT     = 9;   // edges from accept edge to out_valid edge
  localparam int THRU    = 11;
  localparam int RUN_CYC = 9;
`else
  localparam int LAT     = 8;
  localparam int THRU    = 10;
  localparam int RUN_CYC = 8;
`endif

  typedef logic [7:0][7:0][SIZE-1:0]     blk_in_t;
  typedef logic [7:0][7:0][SIZE_OUT-1:0] blk_out_t;

  localparam logic [SIZE-1:0] MIN_V = {1'b1, {(SIZE-1){1'b0}}};
  localparam logic [SIZE-1:0] MAX_V = {1'b0, {(SIZE-1){1'b1}}};

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          in_valid;
  logic                          in_ready;
  blk_in_t                       in_data;
  logic                          approx_req;
  logic [7:0][SIZE-1:0]          col_data_out;
  logic                          col_approx_en;
  logic [7:0][SIZE_OUT-1:0]      col_data_in;
  logic                          out_valid;
  logic                          out_ready;
  blk_out_t                      out_data;
  logic                          busy;

  dct_stage2_seq #(.SIZE(SIZE), .SIZE_OUT(SIZE_OUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .approx_req   (approx_req),
    .col_data_out (col_data_out),
    .col_approx_en(col_approx_en),
    .col_data_in  (col_data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Stub column unit: sign-extends every sample.
  always_comb begin
    col_data_in = '0;
    for (int r = 0; r < 8; r++) begin
      col_data_in[r] = {{(SIZE_OUT-SIZE){col_data_out[r][SIZE-1]}}, col_data_out[r]};
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic blk_in_t gen(input int kind);
    blk_in_t d;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        case (kind)
          0:       d[c][r] = SIZE'(c * 8 + r);
          1:       d[c][r] = ((c + r) % 2 == 1) ? MAX_V : MIN_V;
          2:       d[c][r] = SIZE'($urandom);
          3:       d[c][r] = '1;
          default: d[c][r] = SIZE'(-(c * 8 + r));
        endcase
      end
    end
    return d;
  endfunction

  function automatic blk_out_t model(input blk_in_t d);
    blk_out_t o;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        o[c][r] = SIZE_OUT'($signed(d[c][r]));
      end
    end
    return o;
  endfunction

  function automatic int diff_count(input blk_out_t a, input blk_out_t b);
    int n = 0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        if (a[c][r] !== b[c][r]) n++;
      end
    end
    return n;
  endfunction

  // Scoreboard and monitor state.
  blk_out_t sb[$];
  int       acc_edge   = 0;
  int       approx_cnt = 0;
  int       want_apx   = 0;
  bit       pending    = 0;
  bit       ov_seen    = 0;
  int       n_out      = 0;

  always @(negedge clk) begin
    if (rst) begin
      pending    = 0;
      ov_seen    = 0;
      approx_cnt = 0;
    end else begin
      if (col_approx_en) approx_cnt++;
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data));
        acc_edge   = cyc + 1;
        approx_cnt = 0;
        pending    = 1;
        ov_seen    = 0;
        $display("accept block approx=%0b at edge %0d", approx_req, acc_edge);
      end
      if (out_valid && pending && !ov_seen) begin
        ov_seen = 1;
        check((cyc - acc_edge) == LAT, "latency", cyc - acc_edge, LAT);
        check(approx_cnt == want_apx, "approx_cycles", approx_cnt, want_apx);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_output", 1, 0);
        end else begin
          blk_out_t e;
          int n;
          e = sb.pop_front();
          n = diff_count(out_data, e);
          check(n == 0, "out_data_elems_wrong", n, 0);
          n_out++;
          $display("output block %0d at edge %0d, %0d element mismatches", n_out, cyc + 1, n);
        end
        pending = 0;
      end
    end
  end

  // Driver tasks: entered and left at posedge + #1.
  task automatic send(input blk_in_t d, input bit apx);
    bit got = 0;
    in_data    = d;
    approx_req = apx;
    in_valid   = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check(1'b0, "accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    bit got = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) check(1'b0, "out_valid_timeout", 0, 1);
  endtask

  task automatic release_out(input int hold);
    wait_out_valid();
    @(posedge clk); #1;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    int kind;
    bit apx;
    bit toggle;
    int hold;
    int exp_apx;
  } vec_t;

  vec_t    vecs [5];
  blk_in_t blk_a, blk_b;
  int      acc [3];
  bit      bad;

  initial begin
    vecs[0] = '{0, 1'b0, 1'b0, 0, 0};
    vecs[1] = '{1, 1'b1, 1'b1, 3, RUN_CYC};
    vecs[2] = '{2, 1'b0, 1'b1, 0, 0};
    vecs[3] = '{3, 1'b1, 1'b0, 5, RUN_CYC};
    vecs[4] = '{4, 1'b0, 1'b0, 1, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; approx_req = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(col_approx_en == 1'b0, "rst_col_approx_en", col_approx_en, 0);
    check(col_data_out == '0, "rst_col_data_out_nonzero", (col_data_out != '0), 0);
    check(out_data == '0, "rst_out_data_nonzero", (out_data != '0), 0);
    rst = 1'b0;
    @(negedge clk);
    check(in_ready == 1'b1, "idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Table-driven blocks.
    for (int i = 0; i < 5; i++) begin
      want_apx = vecs[i].exp_apx;
      send(gen(vecs[i].kind), vecs[i].apx);
      if (vecs[i].toggle) approx_req = ~approx_req;
      release_out(vecs[i].hold);
      approx_req = 1'b0;
    end

    // Backpressure in DONE with a new block waiting upstream.
    want_apx = 0;
    blk_a = gen(2);
    blk_b = gen(4);
    send(blk_a, 1'b0);
    wait_out_valid();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = blk_b;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (diff_count(out_data, model(blk_a)) != 0 || in_ready || !out_valid || !busy) bad = 1;
    end
    check(!bad, "backpressure_hold_broken", bad, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check(in_ready == 1'b1 && out_valid == 1'b0, "idle_after_handshake", {in_ready, out_valid}, 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    release_out(0);

    // Back-to-back blocks, sink always ready.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit got = 0;
      in_data  = gen(k == 1 ? 1 : 2);
      in_valid = 1'b1;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (in_ready) begin
          got = 1;
          break;
        end
      end
      if (!got) check(1'b0, "b2b_accept_timeout", k, 0);
      acc[k] = cyc + 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check(acc[1] - acc[0] == THRU, "b2b_spacing_0_1", acc[1] - acc[0], THRU);
    check(acc[2] - acc[1] == THRU, "b2b_spacing_1_2", acc[2] - acc[1], THRU);

    // Reset while column 4 is being driven.
    blk_a = gen(0);
    send(blk_a, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check(col_data_out == blk_a[4], "col4_driven_wrong", (col_data_out != blk_a[4]), 0);
    check(col_approx_en == 1'b1, "col4_approx_en", col_approx_en, 1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check(in_ready == 1'b1, "midrst_in_ready", in_ready, 1);
    check(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
    check(busy == 1'b0, "midrst_busy", busy, 0);
    check(out_data == '0, "midrst_out_data_nonzero", (out_data != '0), 0);
    @(posedge clk); #1;
    want_apx = 0;
    send(gen(1), 1'b0);
    release_out(2);

    @(negedge clk);
    check(sb.size() == 0, "scoreboard_leftover", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dct_stage2_seq.md
# dct_stage2_seq

Sequencer that runs the second (column) DCT pass on an 8x8 block through one shared `dct_col_comb` instance instead of eight parallel ones. It accepts a block from stage 1 with a valid/ready handshake and feeds one column per cycle to the external column unit. It collects the eight results into an output buffer and presents the transformed block downstream with a valid/ready handshake. It trades roughly 8x area in the column datapath for about 10 cycles per block.

## Interface
- `SIZE`, 10, input sample width (signed); must match the shared column unit's `SIZE`
- `SIZE_OUT`, SIZE+2, column-unit output width (signed)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input block valid
- `in_ready`  out  1  sequencer can accept a block
- `in_data`  in  [7:0][7:0] x SIZE  block; `in_data[c]` is column c
- `approx_req`  in  1  approximate-mode request for this block, sampled with the block
- `col_data_out`  out  [7:0] x SIZE  column currently driven to the shared column unit
- `col_approx_en`  out  1  drives the column unit's `approx_en`
- `col_data_in`  in  [7:0] x SIZE_OUT  column-unit result (combinational from `col_data_out`)
- `out_valid`  out  1  output block valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  [7:0][7:0] x SIZE_OUT  result block; `out_data[c]` = column c result
- `busy`  out  1  high in RUN and DONE

## Operation
- Storage:
  - input buffer `ibuf`: 64 x SIZE
  - output buffer `obuf`: 64 x SIZE_OUT
  - 3-bit column counter `col`
  - latched approx bit
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: copy `in_data` to `ibuf`, latch `approx_req`, set `col`=0, go to RUN.
- RUN:
  - Each cycle: `col_data_out`=`ibuf[col]`; write `col_data_in` into `obuf[col]`; increment `col`.
  - When `col`==7 and the write completes, go to DONE.
  - `in_ready`=0.
- DONE:
  - `out_valid`=1; `out_data`=`obuf`, held stable until the handshake.
  - On `out_ready`: go to IDLE.
  - `in_ready`=0 in DONE, so the handshake cycle cannot also accept a new block.
- `col_approx_en` equals the latched approx bit in RUN and is 0 otherwise. `approx_req` changes mid-block are ignored.
- `col_data_out` is all-zero outside RUN.
- No arithmetic in this block. Data passes bit-exact; width growth happens in the column unit only.
- `in_valid` while not in IDLE is ignored. The upstream stage holds its data until `in_ready`.
- Reset mid-block: the current block is discarded without output.
  - state=IDLE, `col`=0, `obuf` and `ibuf` cleared to 0.
  - `out_valid` drops on the cycle after the reset edge.

## Timing
- Reset values (after the rst edge, and while rst is held): `in_ready`=1, `out_valid`=0, `busy`=0, `col_approx_en`=0, `col_data_out`=0, `out_data`=0.
- All outputs come from registers or from the FSM state plus registers. No combinational path from `in_valid`/`out_ready` to any output except through the state.
- Latency:
  - Input handshake at edge T0.
  - RUN covers cycles T0+1 through T0+8 (columns 0..7).
  - `out_valid` rises after edge T0+8, i.e. it is visible in cycle T0+9.
- Throughput: with `out_ready` tied high, one block per 10 cycles (IDLE, 8x RUN, DONE).
- Backpressure: `out_valid`, `out_data` and `busy` stay constant for as long as `out_ready`=0, for any number of cycles.

## Configuration
- `DCT_SEQ_COL_REG_EN` defined:
  - `col_data_in` is registered for one cycle before being written to `obuf`, to break the long combinational path through the column unit.
  - The `obuf` write index lags `col` by one.
  - RUN lasts 9 cycles (8 drives plus 1 drain). `out_valid` is visible in cycle T0+10.
  - Throughput is one block per 11 cycles.
- Undefined: direct write as described in Operation; the column unit is in the same cycle's path.

## Test plan
- Reset, then `in_data[c][r]`=c*8+r, `approx_req`=0, stub column unit returns each input sign-extended -> `out_valid` in cycle T0+9 (T0+10 with macro); `out_data[c][r]`=c*8+r; `col_approx_en`=0 throughout.
- `approx_req`=1 at accept, then toggled to 0 during RUN -> `col_approx_en`=1 for exactly 8 cycles (9 with macro); output still correct.
- Hold `out_ready`=0 for 20 cycles in DONE, with `in_valid`=1 and new data -> `out_data` unchanged, `in_ready`=0, new block not taken; `out_ready`=1 -> IDLE next cycle; second block accepted at the following edge.
- Back-to-back blocks with `out_ready`=1 and `in_valid` always high -> accepts spaced exactly 10 cycles apart (11 with macro); the two results match independent references.
- Assert `rst` at RUN column 4 -> next cycle IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0; the next block processes correctly.
- Signed extremes: inputs -512 and +511 (SIZE=10) with a real `dct_col_comb` attached -> `out_data` matches the eight-instance parallel stage2 output bit-exactly.
